// File: rtl/player_hit_pkg.sv
// Shared constants and state encoding for the player collision responder.
// Sprite geometry is in scaled pixels; the timer counts video frames.
package player_hit_pkg;

    localparam int RES_V              = 480;
    localparam int PROJ_HEIGHT_SCALED = 8;

    localparam int PLAYER_Y       = 440;
    localparam int PLAYER_W       = 26;
    localparam int PLAYER_H       = 16;
    localparam int PROJ_W         = 2;
    localparam int PROJ_H         = PROJ_HEIGHT_SCALED;
    localparam int INIT_LIVES     = 3;
    localparam int EXPLODE_FRAMES = 60;

    localparam int CW = 10;
    localparam int TW = 6;

    typedef enum logic [2:0] {
        ALIVE = 3'd0,
        CHK1  = 3'd1,
        CHK2  = 3'd2,
        CHK3  = 3'd3,
        HIT   = 3'd4,
        OVER  = 3'd5
    } state_t;

endpackage

// File: rtl/player_hit_box_overlap.sv
// Combinational half-open box overlap between one missile and the player.
// Sums are widened to 11 bits so edge arithmetic never wraps.
module box_overlap
    import player_hit_pkg::*;
(
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] mx,
    input  logic [CW-1:0] my,
    output logic          hit
);

    logic [CW:0] px_e;
    logic [CW:0] mx_e;
    logic [CW:0] my_e;

    assign px_e = {1'b0, px};
    assign mx_e = {1'b0, mx};
    assign my_e = {1'b0, my};

    // All four edge comparisons must hold; touching edges do not count.
    always_comb begin
        hit = (mx_e < px_e + 11'(PLAYER_W))
           && (px_e < mx_e + 11'(PROJ_W))
           && (my_e < 11'(PLAYER_Y + PLAYER_H))
           && (11'(PLAYER_Y) < my_e + 11'(PROJ_H));
    end

endmodule

// File: rtl/player_hit.sv
// Per-frame missile vs player collision check with lives, explosion
// timer and game-over tracking. One shared comparator walks m1..m3.
module player_hit
    import player_hit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          frame,
    input  logic [CW-1:0] player_x,
    input  logic [CW-1:0] m1_x,
    input  logic [CW-1:0] m1_y,
    input  logic [CW-1:0] m2_x,
    input  logic [CW-1:0] m2_y,
    input  logic [CW-1:0] m3_x,
    input  logic [CW-1:0] m3_y,
    output logic [1:0]    player_collision,
    output logic [1:0]    lives,
    output logic          exploding,
    output logic          game_over
);

    state_t state;
    state_t next_state;

    logic [CW-1:0] snap_px;
    logic [CW-1:0] snap_x [3];
    logic [CW-1:0] snap_y [3];
    logic [TW-1:0] timer;

    logic [CW-1:0] sel_x;
    logic [CW-1:0] sel_y;
    logic [1:0]    chk_idx;
    logic          is_chk;
    logic          hit;
    logic          last_frame;

    box_overlap u_overlap (
        .px  (snap_px),
        .mx  (sel_x),
        .my  (sel_y),
        .hit (hit)
    );

    // Pick the snapshot of the missile being tested in this check state.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        chk_idx = 2'd0;
        is_chk  = 1'b0;
        case (state)
            CHK1: begin
                sel_x   = snap_x[0];
                sel_y   = snap_y[0];
                chk_idx = 2'd1;
                is_chk  = 1'b1;
            end
            CHK2: begin
                sel_x   = snap_x[1];
                sel_y   = snap_y[1];
                chk_idx = 2'd2;
                is_chk  = 1'b1;
            end
            CHK3: begin
                sel_x   = snap_x[2];
                sel_y   = snap_y[2];
                chk_idx = 2'd3;
                is_chk  = 1'b1;
            end
            default: ;
        endcase
    end

    assign last_frame = frame && (timer == TW'(EXPLODE_FRAMES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ALIVE;
        else     state <= next_state;
    end

    // Next-state: snapshot, three checks in priority order, explosion, over.
    always_comb begin
        next_state = state;
        case (state)
            ALIVE: if (frame) next_state = CHK1;
            CHK1:  next_state = hit ? HIT : CHK2;
            CHK2:  next_state = hit ? HIT : CHK3;
            CHK3:  next_state = hit ? HIT : ALIVE;
            HIT: begin
                if (last_frame)
                    next_state = (lives == 2'd0) ? OVER : ALIVE;
            end
            OVER:    next_state = OVER;
            default: next_state = ALIVE;
        endcase
    end

    // Outputs derived purely from state.
    always_comb begin
        game_over = (state == OVER);
    end

    // Snapshot, collision pulse, lives, explosion flag and frame timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_px          <= '0;
            snap_x           <= '{default: '0};
            snap_y           <= '{default: '0};
            player_collision <= 2'd0;
            lives            <= 2'(INIT_LIVES);
            exploding        <= 1'b0;
            timer            <= '0;
        end else begin
            player_collision <= 2'd0;
            if (state == ALIVE && frame) begin
                snap_px   <= player_x;
                snap_x[0] <= m1_x;
                snap_y[0] <= m1_y;
                snap_x[1] <= m2_x;
                snap_y[1] <= m2_y;
                snap_x[2] <= m3_x;
                snap_y[2] <= m3_y;
            end
            if (is_chk && hit) begin
                player_collision <= chk_idx;
                if (lives != 2'd0) lives <= lives - 2'd1;
                timer     <= '0;
                exploding <= 1'b1;
            end
            if (state == HIT && frame) begin
                timer <= timer + TW'(1);
                if (last_frame) exploding <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_player_hit.sv
// Scoreboard bench for player_hit: a frame-level reference model queues
// expected collisions; a monitor pops them when the DUT reports a hit.
module tb_player_hit;

    localparam int PY = 440;
    localparam int PW = 26;
    localparam int PH = 16;
    localparam int MW = 2;
    localparam int MH = 8;

    typedef struct {
        int idx;
        int cyc;
        int lives;
        int expl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 1'b0;
    logic [9:0] px = '0;
    logic [9:0] mx [3];
    logic [9:0] my [3];
    logic [1:0] player_collision;
    logic [1:0] lives;
    logic       exploding;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q[$];
    exp_t e;

    int m_lives = 3;
    int m_cnt = 0;
    bit m_expl = 0;
    bit m_go = 0;

    player_hit dut (
        .clk              (clk),
        .rst              (rst),
        .frame            (frame),
        .player_x         (px),
        .m1_x             (mx[0]),
        .m1_y             (my[0]),
        .m2_x             (mx[1]),
        .m2_y             (my[1]),
        .m3_x             (mx[2]),
        .m3_y             (my[2]),
        .player_collision (player_collision),
        .lives            (lives),
        .exploding        (exploding),
        .game_over        (game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit ovl(int p, int x, int y);
        return (x < p + PW) && (p < x + MW) && (y < PY + PH) && (PY < y + MH);
    endfunction

    // Frame-level behaviour: first overlapping missile costs a life,
    // then 60 frames of explosion, then game over if no lives remain.
    task automatic model_frame(int t);
        if (m_go) return;
        if (m_expl) begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_expl = 0;
                if (m_lives == 0) m_go = 1;
            end
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (ovl(int'(px), int'(mx[i]), int'(my[i]))) begin
                if (m_lives > 0) m_lives--;
                m_expl = 1;
                m_cnt = 0;
                q.push_back('{idx: i + 1, cyc: t + 2 + i,
                              lives: m_lives, expl: 1});
                return;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_lives = 3;
        m_cnt = 0;
        m_expl = 0;
        m_go = 0;
    endtask

    task automatic place(int p, int x1, int y1, int x2, int y2,
                         int x3, int y3);
        px = 10'(p);
        mx[0] = 10'(x1); my[0] = 10'(y1);
        mx[1] = 10'(x2); my[1] = 10'(y2);
        mx[2] = 10'(x3); my[2] = 10'(y3);
    endtask

    task automatic scramble();
        for (int i = 0; i < 3; i++) begin
            mx[i] = 10'($urandom_range(0, 1023));
            my[i] = 10'($urandom_range(0, 1023));
        end
        px = 10'($urandom_range(0, 1023));
    endtask

    task automatic set_rand();
        int v;
        px = 10'($urandom_range(0, 1000));
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = int'(px) + int'($urandom_range(0, 40)) - 14;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                mx[i] = 10'(v);
                my[i] = 10'($urandom_range(425, 462));
            end else begin
                mx[i] = 10'($urandom_range(0, 1023));
                my[i] = 10'($urandom_range(0, 1023));
            end
        end
    endtask

    task automatic check_state(string tag);
        chk({tag, ".lives"}, int'(lives), m_lives);
        chk({tag, ".exploding"}, int'(exploding), int'(m_expl));
        chk({tag, ".game_over"}, int'(game_over), int'(m_go));
        chk({tag, ".collision_idle"}, int'(player_collision), 0);
    endtask

    task automatic do_frame(bit scr, int gap, string tag);
        int t;
        @(negedge clk);
        frame = 1'b1;
        t = cyc;
        model_frame(t);
        @(negedge clk);
        frame = 1'b0;
        if (scr) scramble();
        repeat (5 + gap) @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset(string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk({tag, ".rst_collision"}, int'(player_collision), 0);
        chk({tag, ".rst_lives"}, int'(lives), 3);
        chk({tag, ".rst_exploding"}, int'(exploding), 0);
        chk({tag, ".rst_game_over"}, int'(game_over), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every reported collision must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && player_collision != 2'd0) begin
            if (q.size() == 0) begin
                chk("unexpected_collision", int'(player_collision), 0);
            end else begin
                e = q.pop_front();
                chk("collision_idx", int'(player_collision), e.idx);
                chk("collision_cycle", cyc, e.cyc);
                chk("collision_lives", int'(lives), e.lives);
                chk("collision_exploding", int'(exploding), e.expl);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.collision", int'(player_collision), 0);
        chk("reset.lives", int'(lives), 3);
        chk("reset.exploding", int'(exploding), 0);
        chk("reset.game_over", int'(game_over), 0);
        rst = 1'b0;

        place(300, 300, 100, 320, 100, 340, 100);
        do_frame(1'b0, 0, "no_overlap");
        place(300, 300, 100, 320, 100, 340, 100);
        do_frame(1'b0, 0, "no_overlap_again");

        do_reset("single");
        place(300, 0, 100, 310, 436, 600, 100);
        do_frame(1'b1, 0, "single_hit_m2");

        do_reset("simul");
        place(300, 305, 440, 0, 100, 320, 445);
        do_frame(1'b1, 0, "simultaneous");

        do_reset("e326");
        place(300, 326, 440, 0, 100, 0, 100);
        do_frame(1'b0, 0, "edge_x326");
        do_reset("e325");
        place(300, 325, 440, 0, 100, 0, 100);
        do_frame(1'b0, 0, "edge_x325");
        do_reset("e432");
        place(300, 310, 432, 0, 100, 0, 100);
        do_frame(1'b0, 0, "edge_y432");
        do_reset("e433");
        place(300, 310, 433, 0, 100, 0, 100);
        do_frame(1'b0, 0, "edge_y433");

        do_reset("exhaust");
        place(300, 305, 440, 0, 100, 0, 100);
        for (int h = 0; h < 3; h++) begin
            do_frame(1'b0, 0, "exhaust_hit");
            for (int f = 0; f < 60; f++) do_frame(1'b0, 0, "exhaust_expl");
        end
        chk("exhaust.game_over", int'(game_over), 1);
        chk("exhaust.lives", int'(lives), 0);
        for (int f = 0; f < 3; f++) do_frame(1'b0, 0, "after_over");

        do_reset("midexpl_pre");
        place(300, 305, 440, 0, 100, 0, 100);
        do_frame(1'b0, 0, "midexpl_hit");
        for (int f = 0; f < 30; f++) do_frame(1'b0, 0, "midexpl_frames");
        do_reset("midexpl");
        place(300, 0, 100, 0, 100, 320, 445);
        do_frame(1'b0, 0, "after_midexpl_rst");

        do_reset("random");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset("rand_rst");
            set_rand();
            do_frame(1'b1, int'($urandom_range(0, 3)), "random");
        end

        repeat (6) @(negedge clk);
        chk("pending_expected", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_hit.md
# player_hit

Collision responder for the invader missile generator. Once per frame it snapshots the three invader missile positions and tests each against the player sprite. On the first hit it returns a one-cycle missile index on `player_collision`, which causes that missile to respawn. It also owns the player's lives counter, explosion timer and game-over flag, and sits between the missile generator and the player and score logic.

## Interface
- PLAYER_Y, 440: fixed top row of the player sprite.
- PLAYER_W, 26: player sprite width in pixels (scaled).
- PLAYER_H, 16: player sprite height in pixels (scaled).
- PROJ_W, 2: missile width in pixels (scaled).
- PROJ_H, 8: missile height in pixels (scaled).
- INIT_LIVES, 3: lives loaded at reset.
- EXPLODE_FRAMES, 60: number of frames spent in the explosion state.
---
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- frame  in  1  one-cycle pulse per video frame.
- player_x  in  10  left edge of the player sprite.
- m1_x, m1_y, m2_x, m2_y, m3_x, m3_y  in  10 each  top-left corner of each missile.
- player_collision  out  2  0 = none, 1..3 = index of the missile that hit; high for one cycle only.
- lives  out  2  remaining lives.
- exploding  out  1  high while the explosion timer runs.
- game_over  out  1  sticky until `rst`.

## Operation
- States: ALIVE, CHK1, CHK2, CHK3, HIT, OVER.
- Reset values: state ALIVE, `player_collision` 0, `lives` INIT_LIVES, `exploding` 0, `game_over` 0, timer 0, snapshot registers 0.
- ALIVE
  - On `frame`, register all six missile coordinates and `player_x` into snapshot registers, then go to CHK1.
- CHKn
  - Test missile n with the overlap rule below.
  - On a hit: `player_collision` <= n, `lives` <= `lives` - 1, timer cleared, `exploding` <= 1, go to HIT.
  - On a miss: go to CHK(n+1). A miss in CHK3 returns to ALIVE.
  - Priority is fixed m1 > m2 > m3. At most one hit is reported per frame.
- Overlap rule: all four comparisons are true.
  - mx < px + PLAYER_W
  - px < mx + PROJ_W
  - my < PLAYER_Y + PLAYER_H
  - PLAYER_Y < my + PROJ_H
  - All sums are computed at 11 bits so there is no wrap. Edges are half-open: touching boxes do not overlap.
- HIT
  - No detection is performed. Each `frame` increments the timer (6 bits).
  - On the `frame` where timer == EXPLODE_FRAMES - 1: `exploding` <= 0. Go to OVER if `lives` == 0, otherwise go to ALIVE.
- OVER: `game_over` = 1. All inputs are ignored until `rst`.
- `player_collision` returns to 0 the cycle after it is asserted. This is unconditional.
- `lives` saturates at 0 and never decrements below it.
- `rst` asserted in any state returns every register to its reset value immediately.

## Timing
- Frame pulse in cycle T. Snapshot is valid from T+1. CHK1 is evaluated in T+1, CHK2 in T+2, CHK3 in T+3.
- Hit on m1 gives `player_collision` = 1 in cycle T+2. Hit on m2 gives 2 in T+3. Hit on m3 gives 3 in T+4.
- `lives` and `exploding` update on the same edge as `player_collision`.
- A `frame` that arrives in CHK1..CHK3 is dropped. The frame period must be at least 5 cycles.
- Missile movement during a check does not affect the result, because the snapshot is used.
- `player_collision` always falls in a non-frame cycle, so the missile generator's respawn path sees it.

## Structure
- Shared constants file: PLAYER_Y, PLAYER_W, PLAYER_H, PROJ_W, PROJ_H, INIT_LIVES, EXPLODE_FRAMES, and the state encoding, alongside the existing PROJ_HEIGHT_SCALED and RES_V.
- One sub-module, `box_overlap`: a combinational 4-comparison test, instanced once. A mux selects missile n by state, so one comparator is shared across CHK1..CHK3.

## Test plan
- No overlap: player_x=300, all missiles at y=100, one `frame` -> `player_collision` stays 0, `lives` stays 3, state is back in ALIVE at T+4.
- Single hit: player_x=300, m2=(310,436), `frame` -> `player_collision`=2 in T+3 only, `lives`=2, `exploding`=1.
- Simultaneous overlap: m1=(305,440), m3=(320,445) both overlapping -> only `player_collision`=1 at T+2, `lives`=2, m3 not reported.
- Edge boundaries with player_x=300:
  - m1_x=326, y=440 -> no hit.
  - m1_x=325 -> hit.
  - m1_y=432 -> no hit.
  - m1_y=433 -> hit.
- Lives exhaustion: three hits, each followed by 60 frames -> `lives` 3→2→1→0. The 60th frame after the third hit sets `game_over`=1; further overlapping frames produce no collision.
- Reset mid-explosion: assert `rst` at HIT frame 30 -> all outputs take reset values immediately. The next overlapping frame is detected normally.
